// File: rtl/rf_wb_pkg.sv
// Shared constants and types for the register-file writeback front end.
package rf_wb_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int RD_W = $clog2(NREG);

  typedef logic [RD_W-1:0] rd_t;
  typedef logic [XLEN-1:0] data_t;

  typedef struct packed {
    rd_t   rd;
    data_t data;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_LSU
  } src_e;

  // Writes to x0 are consumed but never reach the register file.
  function automatic logic is_x0(input rd_t rd);
    return rd == '0;
  endfunction

endpackage

// File: rtl/rf_writeback_arb_if.sv
// Writeback, issue and hazard-query signals between the pipeline and rf_writeback_arb.
interface rf_writeback_arb_if
  import rf_wb_pkg::*;
;

  logic  alu_valid;
  rd_t   alu_rd;
  data_t alu_data;
  logic  alu_stall;

  logic  lsu_valid;
  logic  lsu_ready;
  rd_t   lsu_rd;
  data_t lsu_data;

  logic  iss_valid;
  rd_t   iss_rd;

  rd_t   q_rs1;
  rd_t   q_rs2;
  logic  q_busy1;
  logic  q_busy2;

  logic  reg_we;
  rd_t   reg_rd;
  data_t reg_wdata;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output iss_valid, iss_rd,
    output q_rs1, q_rs2,
    input  alu_stall, lsu_ready,
    input  q_busy1, q_busy2,
    input  reg_we, reg_rd, reg_wdata
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  iss_valid, iss_rd,
    input  q_rs1, q_rs2,
    output alu_stall, lsu_ready,
    output q_busy1, q_busy2,
    output reg_we, reg_rd, reg_wdata
  );

endinterface

// File: rtl/rf_wb_fifo.sv
// Synchronous FIFO of writeback requests; pointers carry an extra wrap bit to tell full from empty.
module rf_wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push_i,
  input  wb_req_t din_i,
  input  logic    pop_i,
  output wb_req_t dout_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  wb_req_t     mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is data-only; emptiness is tracked purely by the pointers.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/rf_writeback_arb.sv
// Merges ALU and buffered LSU writebacks onto one registered RF write port and tracks pending
// long-op destinations for RAW stalls. Define RF_WB_BYPASS_EN to let an idle LSU write skip the buffer.
module rf_writeback_arb
  import rf_wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input logic               clk,
  input logic               rst_n,
  rf_writeback_arb_if.slave wb_if
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  wb_req_t fifo_din, fifo_dout;
  logic    fifo_push, fifo_pop, fifo_full, fifo_empty;

  logic    lsu_fire;
  logic    bypass;
  src_e    sel;
  wb_req_t win;

  logic [CNT_W-1:0] starve_q, starve_d;
  logic             alu_stall_q, alu_stall_d;

  logic [NREG-1:0] sb_q, sb_d, sb_set, sb_clr;

  logic  reg_we_q, reg_we_d;
  rd_t   reg_rd_q, reg_rd_d;
  data_t reg_wdata_q, reg_wdata_d;

  rf_wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .din_i   (fifo_din),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Arbitration: ALU first, then buffered LSU head, then (optionally) a direct LSU transfer.
  always_comb begin
    lsu_fire      = wb_if.lsu_valid && !fifo_full;
    sel           = SRC_NONE;
    win           = '0;
    fifo_pop      = 1'b0;
    bypass        = 1'b0;
    fifo_din.rd   = wb_if.lsu_rd;
    fifo_din.data = wb_if.lsu_data;

    if (wb_if.alu_valid) begin
      sel      = SRC_ALU;
      win.rd   = wb_if.alu_rd;
      win.data = wb_if.alu_data;
    end else if (!fifo_empty) begin
      sel      = SRC_LSU;
      win      = fifo_dout;
      fifo_pop = 1'b1;
    end
`ifdef RF_WB_BYPASS_EN
    else if (lsu_fire) begin
      sel    = SRC_LSU;
      win    = fifo_din;
      bypass = 1'b1;
    end
`endif

    fifo_push = lsu_fire && !bypass;
  end

  // Starvation: count ALU-blocked cycles with a waiting head; the stall cycle lets the head out.
  always_comb begin
    starve_d = starve_q;
    if (fifo_pop) begin
      starve_d = '0;
    end else if (!fifo_empty && wb_if.alu_valid && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + CNT_ONE;
    end
    alu_stall_d = (starve_d == STARVE_LIM) && !fifo_pop;
  end

  // Scoreboard: an issue to the same rd in the commit cycle keeps the bit set.
  always_comb begin
    sb_set = '0;
    sb_clr = '0;
    if (wb_if.iss_valid && !is_x0(wb_if.iss_rd)) sb_set[wb_if.iss_rd] = 1'b1;
    if (sel == SRC_LSU) sb_clr[win.rd] = 1'b1;
    sb_d = sb_set | (sb_q & ~sb_clr);
  end

  always_comb begin
    reg_we_d    = (sel != SRC_NONE) && !is_x0(win.rd);
    reg_rd_d    = reg_rd_q;
    reg_wdata_d = reg_wdata_q;
    if (sel != SRC_NONE) begin
      reg_rd_d    = win.rd;
      reg_wdata_d = win.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q    <= '0;
      alu_stall_q <= 1'b0;
      sb_q        <= '0;
      reg_we_q    <= 1'b0;
      reg_rd_q    <= '0;
      reg_wdata_q <= '0;
    end else begin
      starve_q    <= starve_d;
      alu_stall_q <= alu_stall_d;
      sb_q        <= sb_d;
      reg_we_q    <= reg_we_d;
      reg_rd_q    <= reg_rd_d;
      reg_wdata_q <= reg_wdata_d;
    end
  end

  assign wb_if.alu_stall = alu_stall_q;
  assign wb_if.lsu_ready = !fifo_full;
  assign wb_if.q_busy1   = sb_q[wb_if.q_rs1];
  assign wb_if.q_busy2   = sb_q[wb_if.q_rs2];
  assign wb_if.reg_we    = reg_we_q;
  assign wb_if.reg_rd    = reg_rd_q;
  assign wb_if.reg_wdata = reg_wdata_q;

`ifndef SYNTHESIS
  a_no_alu_during_stall: assert property (@(posedge clk) disable iff (!rst_n)
    !(alu_stall_q && wb_if.alu_valid));
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_push && fifo_full));
`endif

endmodule

// File: tb/tb_rf_writeback_arb.sv
// Bench for rf_writeback_arb: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a queue-based model of the arbitration rules.
module tb_rf_writeback_arb;
  import rf_wb_pkg::*;

  localparam int FIFO_DEPTH = 4;
  localparam int STARVE_MAX = 8;
`ifdef RF_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  rf_writeback_arb_if wb();

  rf_writeback_arb #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb_if (wb)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  wb_req_t     mq[$];
  logic [31:0] pend    = '0;
  int          blocked = 0;
  logic        m_stall = 1'b0;
  logic        m_we    = 1'b0;
  rd_t         m_rd    = '0;
  data_t       m_data  = '0;
  wb_req_t     m_w;
  bit          m_acc, m_took, m_from_lsu, m_popped, m_nonempty;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      pend    = '0;
      blocked = 0;
      m_stall = 1'b0;
      m_we    = 1'b0;
      m_rd    = '0;
      m_data  = '0;
    end else begin
      m_nonempty = (mq.size() > 0);
      m_acc      = wb.lsu_valid && (mq.size() < FIFO_DEPTH);
      m_took     = 0;
      m_from_lsu = 0;
      m_popped   = 0;
      m_w        = '0;
      if (wb.alu_valid) begin
        m_w  = '{rd: wb.alu_rd, data: wb.alu_data};
        m_took = 1;
      end else if (m_nonempty) begin
        m_w        = mq.pop_front();
        m_took     = 1;
        m_from_lsu = 1;
        m_popped   = 1;
      end else if (BYP && m_acc) begin
        m_w        = '{rd: wb.lsu_rd, data: wb.lsu_data};
        m_took     = 1;
        m_from_lsu = 1;
        m_acc      = 0;
      end
      if (m_acc) mq.push_back('{rd: wb.lsu_rd, data: wb.lsu_data});
      if (m_popped) blocked = 0;
      else if (m_nonempty && wb.alu_valid) blocked++;
      m_stall = (blocked == STARVE_MAX);
      if (m_from_lsu) pend[m_w.rd] = 1'b0;
      if (wb.iss_valid && wb.iss_rd != 0) pend[wb.iss_rd] = 1'b1;
      m_we = m_took && (m_w.rd != 0);
      if (m_took) begin
        m_rd   = m_w.rd;
        m_data = m_w.data;
      end
    end
  end

  always @(negedge clk) begin
    chk("lsu_ready", {31'b0, wb.lsu_ready}, {31'b0, mq.size() < FIFO_DEPTH});
    chk("alu_stall", {31'b0, wb.alu_stall}, {31'b0, m_stall});
    chk("reg_we",    {31'b0, wb.reg_we},    {31'b0, m_we});
    if (m_we) begin
      chk("reg_rd",    {27'b0, wb.reg_rd}, {27'b0, m_rd});
      chk("reg_wdata", wb.reg_wdata,       m_data);
    end
    chk("q_busy1", {31'b0, wb.q_busy1}, {31'b0, pend[wb.q_rs1]});
    chk("q_busy2", {31'b0, wb.q_busy2}, {31'b0, pend[wb.q_rs2]});
  end

  // Write log used by directed scenarios.
  wb_req_t wlog[$];
  always @(negedge clk) begin
    if (wb.reg_we === 1'b1) wlog.push_back('{rd: wb.reg_rd, data: wb.reg_wdata});
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb.alu_valid = 1'b0;
    wb.lsu_valid = 1'b0;
    wb.iss_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      idle_inputs();
    end
  endtask

  int n_rd3, n_stall, stall_at, lsu_at, pct;

  initial begin
    wb.alu_valid = 1'b0; wb.alu_rd = '0; wb.alu_data = '0;
    wb.lsu_valid = 1'b0; wb.lsu_rd = '0; wb.lsu_data = '0;
    wb.iss_valid = 1'b0; wb.iss_rd = '0;
    wb.q_rs1 = '0; wb.q_rs2 = '0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_reg_we",    {31'b0, wb.reg_we}, 32'd0);
    chk("rst_reg_rd",    {27'b0, wb.reg_rd}, 32'd0);
    chk("rst_reg_wdata", wb.reg_wdata,       32'd0);
    chk("rst_alu_stall", {31'b0, wb.alu_stall}, 32'd0);
    chk("rst_lsu_ready", {31'b0, wb.lsu_ready}, 32'd1);
    for (int r = 0; r < NREG; r++) begin
      wb.q_rs1 = rd_t'(r);
      #0.2;
      chk("rst_q_busy1", {31'b0, wb.q_busy1}, 32'd0);
    end
    cyc();
    rst_n = 1'b1;
    idle(2);

    // ALU write, one-cycle latency
    wb.alu_valid = 1'b1; wb.alu_rd = 5'd5; wb.alu_data = 32'hDEADBEEF;
    cyc();
    wb.alu_valid = 1'b0;
    @(negedge clk);
    chk("alu_we",    {31'b0, wb.reg_we}, 32'd1);
    chk("alu_rd",    {27'b0, wb.reg_rd}, 32'd5);
    chk("alu_wdata", wb.reg_wdata,       32'hDEADBEEF);

    // Pending bit and LSU latency
    cyc();
    wb.iss_valid = 1'b1; wb.iss_rd = 5'd7; wb.q_rs1 = 5'd7;
    cyc();
    wb.iss_valid = 1'b0;
    @(negedge clk);
    chk("busy7_set", {31'b0, wb.q_busy1}, 32'd1);
    cyc();
    wb.lsu_valid = 1'b1; wb.lsu_rd = 5'd7; wb.lsu_data = 32'h1234;
    @(negedge clk);
    chk("lsu_ready_n", {31'b0, wb.lsu_ready}, 32'd1);
    chk("busy7_n",     {31'b0, wb.q_busy1},   32'd1);
    cyc();
    wb.lsu_valid = 1'b0;
    @(negedge clk);
    chk("lsu_we_n1", {31'b0, wb.reg_we}, {31'b0, BYP});
    if (BYP) begin
      chk("lsu_rd_n1",    {27'b0, wb.reg_rd}, 32'd7);
      chk("lsu_data_n1",  wb.reg_wdata,       32'h1234);
    end
    cyc();
    @(negedge clk);
    chk("lsu_we_n2", {31'b0, wb.reg_we}, {31'b0, !BYP});
    if (!BYP) begin
      chk("lsu_rd_n2",   {27'b0, wb.reg_rd}, 32'd7);
      chk("lsu_data_n2", wb.reg_wdata,       32'h1234);
    end
    chk("busy7_n2", {31'b0, wb.q_busy1}, 32'd0);
    cyc();
    @(negedge clk);
    chk("busy7_n3", {31'b0, wb.q_busy1}, 32'd0);
    idle(3);

    // Five back-to-back LSU pushes drained continuously
    wlog.delete();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) cyc();
      wb.lsu_valid = 1'b1; wb.lsu_rd = 5'd3; wb.lsu_data = 32'hA0 + i;
      @(negedge clk);
      chk("drain_ready", {31'b0, wb.lsu_ready}, 32'd1);
    end
    idle(5);
    chk("drain_count", wlog.size(), 32'd5);
    for (int i = 0; i < 5 && i < wlog.size(); i++) begin
      chk("drain_rd",   {27'b0, wlog[i].rd}, 32'd3);
      chk("drain_data", wlog[i].data,        32'hA0 + i);
    end

    // ALU hogging the port: buffer fills, fifth/sixth offers are refused
    wlog.delete();
    for (int i = 0; i < 6; i++) begin
      cyc();
      wb.alu_valid = 1'b1; wb.alu_rd = 5'd9; wb.alu_data = 32'hC0 + i;
      wb.lsu_valid = 1'b1; wb.lsu_rd = 5'd3; wb.lsu_data = 32'hB0 + i;
      @(negedge clk);
      chk("fill_ready", {31'b0, wb.lsu_ready}, (i < 4) ? 32'd1 : 32'd0);
    end
    idle(9);
    n_rd3 = 0;
    foreach (wlog[k]) begin
      if (wlog[k].rd == 5'd3) begin
        chk("fill_data", wlog[k].data, 32'hB0 + n_rd3);
        n_rd3++;
      end
    end
    chk("fill_count", n_rd3, 32'd4);

    // Starvation: one buffered entry behind continuous ALU traffic
    cyc();
    wb.alu_valid = 1'b1; wb.alu_rd = 5'd9; wb.alu_data = 32'h99;
    wb.lsu_valid = 1'b1; wb.lsu_rd = 5'd4; wb.lsu_data = 32'h55;
    n_stall = 0; stall_at = -1; lsu_at = -1;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      wb.lsu_valid = 1'b0;
      if (wb.alu_stall === 1'b1) begin
        wb.alu_valid = 1'b0;
        n_stall++;
        stall_at = i;
      end else begin
        wb.alu_valid = 1'b1;
      end
      @(negedge clk);
      if (wb.reg_we === 1'b1 && wb.reg_rd == 5'd4) lsu_at = i;
    end
    idle_inputs();
    chk("starve_pulses",   n_stall,  32'd1);
    chk("starve_stall_at", stall_at, 32'd9);
    chk("starve_write_at", lsu_at,   32'd10);
    idle(3);

    // x0 writes: consumed, never written
    wlog.delete();
    wb.alu_valid = 1'b1; wb.alu_rd = 5'd0; wb.alu_data = 32'h1;
    wb.lsu_valid = 1'b1; wb.lsu_rd = 5'd0; wb.lsu_data = 32'h2;
    idle(4);
    for (int i = 0; i < 5; i++) begin
      cyc();
      wb.alu_valid = 1'b1; wb.alu_rd = 5'd0;
      wb.lsu_valid = (i < 4); wb.lsu_rd = 5'd0; wb.lsu_data = 32'h10 + i;
      @(negedge clk);
      if (i == 4) chk("x0_full", {31'b0, wb.lsu_ready}, 32'd0);
    end
    idle(7);
    chk("x0_drained", {31'b0, wb.lsu_ready}, 32'd1);
    chk("x0_no_we",   wlog.size(),          32'd0);

    // Reset mid-operation
    cyc();
    wb.alu_valid = 1'b1; wb.alu_rd = 5'd9; wb.alu_data = 32'h77;
    wb.q_rs1 = 5'd10; wb.q_rs2 = 5'd11;
    for (int i = 0; i < 3; i++) begin
      wb.lsu_valid = 1'b1; wb.lsu_rd = rd_t'(10 + i); wb.lsu_data = 32'hE0 + i;
      wb.iss_valid = (i < 2); wb.iss_rd = rd_t'(10 + i);
      cyc();
    end
    wb.lsu_valid = 1'b0; wb.iss_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy1", {31'b0, wb.q_busy1},   32'd1);
    chk("pre_rst_busy2", {31'b0, wb.q_busy2},   32'd1);
    chk("pre_rst_ready", {31'b0, wb.lsu_ready}, 32'd1);
    chk("pre_rst_model_depth", mq.size(), 32'd3);
    #2;
    rst_n = 1'b0;
    idle_inputs();
    cyc();
    cyc();
    rst_n = 1'b1;
    wlog.delete();
    @(negedge clk);
    chk("post_rst_ready", {31'b0, wb.lsu_ready}, 32'd1);
    chk("post_rst_busy1", {31'b0, wb.q_busy1},   32'd0);
    chk("post_rst_busy2", {31'b0, wb.q_busy2},   32'd0);
    chk("post_rst_model_pend", pend, 32'd0);
    idle(8);
    chk("post_rst_no_we", wlog.size(), 32'd0);

    // Randomized traffic at several ALU densities
    for (int ph = 0; ph < 3; ph++) begin
      pct = (ph == 0) ? 30 : (ph == 1) ? 85 : 10;
      for (int c = 0; c < 400; c++) begin
        cyc();
        wb.alu_valid = (wb.alu_stall !== 1'b1) && ($urandom_range(99) < pct);
        wb.alu_rd    = rd_t'($urandom_range(7));
        wb.alu_data  = $urandom;
        wb.lsu_valid = ($urandom_range(99) < 50);
        wb.lsu_rd    = rd_t'($urandom_range(7));
        wb.lsu_data  = $urandom;
        wb.iss_valid = ($urandom_range(99) < 30);
        wb.iss_rd    = rd_t'($urandom_range(7));
        wb.q_rs1     = rd_t'($urandom_range(7));
        wb.q_rs2     = rd_t'($urandom_range(31));
      end
    end
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
